// File: rtl/surf_autotrain_sequencer_if.sv
// surf_autotrain_sequencer_if: request/response handshake between the link
// bring-up sequencer (master) and the shared output-alignment engine (slave).
interface surf_autotrain_sequencer_if;
  logic       align_req_o;   // level request, held until done/err
  logic [2:0] align_surf_o;  // SURF index being aligned, stable while requested
  logic       align_done_i;  // 1-cycle pulse: alignment succeeded
  logic       align_err_i;   // 1-cycle pulse: alignment failed

  modport master (
    output align_req_o,
    output align_surf_o,
    input  align_done_i,
    input  align_err_i
  );

  modport slave (
    input  align_req_o,
    input  align_surf_o,
    output align_done_i,
    output align_err_i
  );
endinterface

// File: rtl/surf_autotrain_sequencer.sv
// surf_autotrain_sequencer: round-robin SURF link bring-up in the wbclk domain.
// One SURF at a time: enable CIN training, wait for train-out ready, run the
// shared output aligner, then wait for the link to report live and aligned.
// Timeouts and misalignment raise a sticky per-SURF error.
// Optional feature macro: AUTOTRAIN_RETRY_EN (retry a failing SURF up to
// MAX_RETRY times before raising its error bit).
module surf_autotrain_sequencer #(
  parameter int unsigned NUM_SURF     = 7,
  parameter int unsigned TIMEOUT_BITS = 20,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic                       wb_clk_i,
  input  logic                       rst_i,
  input  logic [NUM_SURF-1:0]        autotrain_en_i,
  input  logic [NUM_SURF-1:0]        trainin_req_i,
  input  logic [NUM_SURF-1:0]        trainout_rdy_i,
  input  logic [NUM_SURF-1:0]        surf_live_i,
  input  logic [NUM_SURF-1:0]        surf_misaligned_i,
  input  logic                       err_clear_i,
  surf_autotrain_sequencer_if.master align,
  output logic [NUM_SURF-1:0]        cin_train_o,
  output logic [NUM_SURF-1:0]        train_complete_o,
  output logic [NUM_SURF-1:0]        surf_err_o,
  output logic                       busy_o
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CIN_TRAIN,
    S_ALIGN,
    S_WAIT_LIVE,
    S_FAIL
  } state_t;

  state_t                  state, state_n;
  logic [IDX_W-1:0]        cur, cur_n;
  logic [IDX_W-1:0]        ptr, ptr_n;
  logic [TIMEOUT_BITS-1:0] tcnt, tcnt_n;
  logic [NUM_SURF-1:0]     done, done_n;
  logic [NUM_SURF-1:0]     cin_n, tc_n, err_n;
  logic                    req_n;
  logic [IDX_W-1:0]        surf_n;
  logic                    busy_n;

  logic [NUM_SURF-1:0]     eligible;
  logic                    timeout;
  logic                    abort;
  logic                    go_abort;
  logic                    sel_found;
  logic [IDX_W-1:0]        sel_idx;
  logic [IDX_W-1:0]        cand;
  int unsigned             idx;

`ifdef AUTOTRAIN_RETRY_EN
  localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);
  logic [NUM_SURF-1:0][1:0] retry, retry_n;
`endif

  assign eligible = trainin_req_i & autotrain_en_i & ~done & ~surf_err_o;
  assign timeout  = &tcnt;
  assign abort    = !trainin_req_i[cur];

  // Round-robin pick: first eligible SURF at or after ptr, wrapping past the last index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_SURF; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_SURF) idx = idx - NUM_SURF;
      cand = IDX_W'(idx);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state and output logic: per-SURF housekeeping first, then the sequencer for cur.
  always_comb begin
    state_n  = state;
    cur_n    = cur;
    ptr_n    = ptr;
    tcnt_n   = tcnt;
    done_n   = done;
    cin_n    = cin_train_o;
    tc_n     = train_complete_o;
    err_n    = surf_err_o;
    req_n    = align.align_req_o;
    surf_n   = align.align_surf_o;
    go_abort = 1'b0;
`ifdef AUTOTRAIN_RETRY_EN
    retry_n  = retry;
    if (err_clear_i) retry_n = '0;
`endif

    // Error bits set later in this block override the clear for that bit.
    if (err_clear_i) err_n = '0;

    // Completed SURFs: loss of request re-arms them, misalignment flags them.
    for (int unsigned i = 0; i < NUM_SURF; i++) begin
      if (done[i] && !trainin_req_i[i]) begin
        done_n[i] = 1'b0;
        tc_n[i]   = 1'b0;
        cin_n[i]  = 1'b0;
      end
      if (done[i] && surf_misaligned_i[i]) begin
        err_n[i]  = 1'b1;
        done_n[i] = 1'b0;
        tc_n[i]   = 1'b0;
      end
    end

    unique case (state)
      S_IDLE: begin
        if (sel_found) begin
          state_n        = S_CIN_TRAIN;
          cur_n          = sel_idx;
          cin_n[sel_idx] = 1'b1;
          ptr_n          = (sel_idx == IDX_W'(NUM_SURF - 1)) ? '0 : sel_idx + IDX_W'(1);
        end
      end
      S_CIN_TRAIN: begin
        if (abort) begin
          go_abort = 1'b1;
        end else if (trainout_rdy_i[cur]) begin
          state_n = S_ALIGN;
          req_n   = 1'b1;
          surf_n  = cur;
        end else if (timeout) begin
          state_n = S_FAIL;
        end
      end
      S_ALIGN: begin
        if (abort) begin
          go_abort = 1'b1;
        end else if (align.align_err_i) begin
          state_n = S_FAIL;
          req_n   = 1'b0;
        end else if (align.align_done_i) begin
          state_n   = S_WAIT_LIVE;
          tc_n[cur] = 1'b1;
          req_n     = 1'b0;
        end else if (timeout) begin
          state_n = S_FAIL;
          req_n   = 1'b0;
        end
      end
      S_WAIT_LIVE: begin
        if (abort) begin
          go_abort = 1'b1;
        end else if (surf_live_i[cur] && !surf_misaligned_i[cur]) begin
          state_n     = S_IDLE;
          done_n[cur] = 1'b1;
          cin_n[cur]  = 1'b0;
`ifdef AUTOTRAIN_RETRY_EN
          retry_n[cur] = 2'd0;
`endif
        end else if (surf_misaligned_i[cur] || timeout) begin
          state_n = S_FAIL;
        end
      end
      S_FAIL: begin
        state_n    = S_IDLE;
        cin_n[cur] = 1'b0;
        tc_n[cur]  = 1'b0;
`ifdef AUTOTRAIN_RETRY_EN
        if (retry[cur] < RETRY_LIM) retry_n[cur] = retry[cur] + 2'd1;
        else                        err_n[cur]   = 1'b1;
`else
        err_n[cur] = 1'b1;
`endif
      end
      default: state_n = S_IDLE;
    endcase

    if (go_abort) begin
      state_n    = S_IDLE;
      cin_n[cur] = 1'b0;
      tc_n[cur]  = 1'b0;
      req_n      = 1'b0;
`ifdef AUTOTRAIN_RETRY_EN
      retry_n[cur] = 2'd0;
`endif
    end

    // Step timer restarts on any state change and saturates at all-ones.
    if (state_n != state) begin
      tcnt_n = '0;
    end else if ((state == S_CIN_TRAIN || state == S_ALIGN || state == S_WAIT_LIVE) && !timeout) begin
      tcnt_n = tcnt + TIMEOUT_BITS'(1);
    end

    busy_n = (state_n != S_IDLE);
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge wb_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= S_IDLE;
      cur                <= '0;
      ptr                <= '0;
      tcnt               <= '0;
      done               <= '0;
      cin_train_o        <= '0;
      train_complete_o   <= '0;
      surf_err_o         <= '0;
      align.align_req_o  <= 1'b0;
      align.align_surf_o <= '0;
      busy_o             <= 1'b0;
    end else begin
      state              <= state_n;
      cur                <= cur_n;
      ptr                <= ptr_n;
      tcnt               <= tcnt_n;
      done               <= done_n;
      cin_train_o        <= cin_n;
      train_complete_o   <= tc_n;
      surf_err_o         <= err_n;
      align.align_req_o  <= req_n;
      align.align_surf_o <= surf_n;
      busy_o             <= busy_n;
    end
  end

`ifdef AUTOTRAIN_RETRY_EN
  // Per-SURF failure counts for the retry budget.
  always_ff @(posedge wb_clk_i or posedge rst_i) begin
    if (rst_i) retry <= '0;
    else       retry <= retry_n;
  end
`endif

endmodule

// File: tb/tb_surf_autotrain_sequencer.sv
// tb_surf_autotrain_sequencer: directed table, hand sequences and randomized
// traffic for surf_autotrain_sequencer, checked against a behavioural model.
// Honours AUTOTRAIN_RETRY_EN the same way as the design.
module tb_surf_autotrain_sequencer;

  localparam int unsigned TBITS   = 4;
  localparam int          LIMIT   = (1 << TBITS) - 1;
  localparam int          RETRIES = 2;
`ifdef AUTOTRAIN_RETRY_EN
  localparam int          FAILS_TO_ERR = RETRIES + 1;
`else
  localparam int          FAILS_TO_ERR = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] en, req, rdy, live, mis;
  logic       eclr;
  logic [6:0] cin, tc, err;
  logic       busy;

  surf_autotrain_sequencer_if aif();

  surf_autotrain_sequencer #(
    .NUM_SURF    (7),
    .TIMEOUT_BITS(TBITS),
    .MAX_RETRY   (RETRIES)
  ) dut (
    .wb_clk_i         (clk),
    .rst_i            (rst),
    .autotrain_en_i   (en),
    .trainin_req_i    (req),
    .trainout_rdy_i   (rdy),
    .surf_live_i      (live),
    .surf_misaligned_i(mis),
    .err_clear_i      (eclr),
    .align            (aif),
    .cin_train_o      (cin),
    .train_complete_o (tc),
    .surf_err_o       (err),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {PH_IDLE, PH_CIN, PH_ALIGN, PH_LIVE, PH_FAIL} phase_t;
  phase_t     m_ph;
  int         m_age, m_ptr, m_cur, m_asurf;
  logic [6:0] m_done, m_err, m_cin, m_tc;
  logic       m_areq, m_busy;
  int         m_retry [7];

  task automatic m_reset();
    m_ph = PH_IDLE; m_age = 0; m_ptr = 0; m_cur = 0; m_asurf = 0;
    m_done = '0; m_err = '0; m_cin = '0; m_tc = '0; m_areq = 1'b0; m_busy = 1'b0;
    foreach (m_retry[i]) m_retry[i] = 0;
  endtask

  task automatic m_step();
    phase_t     ph    = m_ph;
    int         cur   = m_cur;
    int         ptr   = m_ptr;
    int         asurf = m_asurf;
    logic [6:0] dn    = m_done;
    logic [6:0] ev    = m_err;
    logic [6:0] cv    = m_cin;
    logic [6:0] tv    = m_tc;
    logic       areq  = m_areq;
    bit         tmo   = (m_age >= LIMIT);
    bit         active = (m_ph == PH_CIN || m_ph == PH_ALIGN || m_ph == PH_LIVE);
    int         rt [7];
    rt = m_retry;
    if (eclr) begin
      ev = '0;
      foreach (rt[i]) rt[i] = 0;
    end
    for (int i = 0; i < 7; i++) begin
      if (m_done[i] && !req[i]) begin dn[i] = 0; tv[i] = 0; cv[i] = 0; end
      if (m_done[i] && mis[i])  begin ev[i] = 1; dn[i] = 0; tv[i] = 0; end
    end
    if (active && !req[m_cur]) begin
      ph = PH_IDLE; cv[cur] = 0; tv[cur] = 0; areq = 0; rt[cur] = 0;
    end else begin
      case (m_ph)
        PH_IDLE: for (int k = 0; k < 7; k++) begin
          int i = (m_ptr + k) % 7;
          if (ph == PH_IDLE && req[i] && en[i] && !m_done[i] && !m_err[i]) begin
            ph = PH_CIN; cur = i; cv[i] = 1; ptr = (i + 1) % 7;
          end
        end
        PH_CIN: begin
          if (rdy[cur]) begin ph = PH_ALIGN; areq = 1; asurf = cur; end
          else if (tmo) ph = PH_FAIL;
        end
        PH_ALIGN: begin
          if (aif.align_err_i)       begin ph = PH_FAIL; areq = 0; end
          else if (aif.align_done_i) begin ph = PH_LIVE; tv[cur] = 1; areq = 0; end
          else if (tmo)              begin ph = PH_FAIL; areq = 0; end
        end
        PH_LIVE: begin
          if (live[cur] && !mis[cur]) begin ph = PH_IDLE; dn[cur] = 1; cv[cur] = 0; rt[cur] = 0; end
          else if (mis[cur] || tmo) ph = PH_FAIL;
        end
        PH_FAIL: begin
          ph = PH_IDLE; cv[cur] = 0; tv[cur] = 0;
`ifdef AUTOTRAIN_RETRY_EN
          if (m_retry[cur] < RETRIES) rt[cur] = m_retry[cur] + 1;
          else                        ev[cur] = 1;
`else
          ev[cur] = 1;
`endif
        end
        default: ;
      endcase
    end
    m_age   = (ph != m_ph) ? 0 : m_age + 1;
    m_ph    = ph; m_cur = cur; m_ptr = ptr; m_asurf = asurf;
    m_done  = dn; m_err = ev; m_cin = cv; m_tc = tv; m_areq = areq;
    m_retry = rt;
    m_busy  = (ph != PH_IDLE);
  endtask

  task automatic check_model(string tag);
    check({tag, ".cin"},  32'(cin),  32'(m_cin));
    check({tag, ".tc"},   32'(tc),   32'(m_tc));
    check({tag, ".err"},  32'(err),  32'(m_err));
    check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check({tag, ".areq"}, 32'(aif.align_req_o), 32'(m_areq));
    if (m_areq) check({tag, ".asurf"}, 32'(aif.align_surf_o), 32'(m_asurf));
  endtask

  // One clock: model and DUT see the same inputs; outputs sampled 1 time unit after the edge.
  task automatic cyc(string tag);
    @(posedge clk);
    m_step();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 7'h7F; req = '0; rdy = '0; live = '0; mis = '0; eclr = 1'b0;
    aif.align_done_i = 1'b0; aif.align_err_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    check("reset.cin",  32'(cin),  32'h0);
    check("reset.tc",   32'(tc),   32'h0);
    check("reset.err",  32'(err),  32'h0);
    check("reset.busy", 32'(busy), 32'h0);
    check("reset.areq", 32'(aif.align_req_o), 32'h0);
    rst = 1'b0;
  endtask

  // Drives a SURF already in CIN training through align and live.
  task automatic complete_link(int idx, string tag);
    logic [6:0] b;
    b = 7'(1 << idx);
    rdy = b;
    cyc(tag);
    check({tag, ".areq_hi"}, 32'(aif.align_req_o), 32'h1);
    check({tag, ".asurf"},   32'(aif.align_surf_o), 32'(idx));
    rdy = '0; aif.align_done_i = 1'b1;
    cyc(tag);
    aif.align_done_i = 1'b0;
    check({tag, ".tc_set"}, 32'(tc & b), 32'(b));
    live = b;
    cyc(tag);
    live = '0;
    check({tag, ".idle"},   32'(busy), 32'h0);
    check({tag, ".cin_lo"}, 32'(cin & b), 32'h0);
  endtask

  typedef struct {
    logic [6:0] req, rdy, live;
    logic       adone, aerr;
    logic [6:0] x_cin, x_tc, x_err;
    logic       x_areq;
    logic [2:0] x_asurf;
    logic       x_busy;
  } vec_t;

  vec_t vt [11];
  localparam logic [6:0] E_AFTER_FAIL0 = (FAILS_TO_ERR == 1) ? 7'h01 : 7'h00;
  localparam logic [6:0] E_T5          = (FAILS_TO_ERR == 1) ? 7'h20 : 7'h00;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //            req    rdy    live   dn ae  cin    tc     err            areq surf busy
    vt[0]  = '{7'h04, 7'h00, 7'h00, 0, 0, 7'h04, 7'h00, 7'h00,         0, 3'd0, 1};
    vt[1]  = '{7'h04, 7'h04, 7'h00, 0, 0, 7'h04, 7'h00, 7'h00,         1, 3'd2, 1};
    vt[2]  = '{7'h04, 7'h00, 7'h00, 0, 0, 7'h04, 7'h00, 7'h00,         1, 3'd2, 1};
    vt[3]  = '{7'h04, 7'h00, 7'h00, 1, 0, 7'h04, 7'h04, 7'h00,         0, 3'd0, 1};
    vt[4]  = '{7'h04, 7'h00, 7'h04, 0, 0, 7'h00, 7'h04, 7'h00,         0, 3'd0, 0};
    vt[5]  = '{7'h04, 7'h00, 7'h04, 0, 0, 7'h00, 7'h04, 7'h00,         0, 3'd0, 0};
    vt[6]  = '{7'h05, 7'h00, 7'h00, 0, 0, 7'h01, 7'h04, 7'h00,         0, 3'd0, 1};
    vt[7]  = '{7'h05, 7'h01, 7'h00, 0, 0, 7'h01, 7'h04, 7'h00,         1, 3'd0, 1};
    vt[8]  = '{7'h05, 7'h00, 7'h00, 1, 1, 7'h01, 7'h04, 7'h00,         0, 3'd0, 1};
    vt[9]  = '{7'h05, 7'h00, 7'h00, 0, 0, 7'h00, 7'h04, E_AFTER_FAIL0, 0, 3'd0, 0};
    vt[10] = '{7'h04, 7'h00, 7'h00, 0, 0, 7'h00, 7'h04, E_AFTER_FAIL0, 0, 3'd0, 0};

    // Table: basic bring-up of SURF 2, then done+err collision on SURF 0.
    do_reset();
    for (int v = 0; v < 11; v++) begin
      req = vt[v].req; rdy = vt[v].rdy; live = vt[v].live;
      aif.align_done_i = vt[v].adone; aif.align_err_i = vt[v].aerr;
      cyc($sformatf("vec%0d", v));
      check($sformatf("vec%0d.cin", v),  32'(cin),  32'(vt[v].x_cin));
      check($sformatf("vec%0d.tc", v),   32'(tc),   32'(vt[v].x_tc));
      check($sformatf("vec%0d.err", v),  32'(err),  32'(vt[v].x_err));
      check($sformatf("vec%0d.areq", v), 32'(aif.align_req_o), 32'(vt[v].x_areq));
      check($sformatf("vec%0d.busy", v), 32'(busy), 32'(vt[v].x_busy));
      if (vt[v].x_areq) check($sformatf("vec%0d.asurf", v), 32'(aif.align_surf_o), 32'(vt[v].x_asurf));
    end
    aif.align_done_i = 1'b0; aif.align_err_i = 1'b0; rdy = '0; live = '0;

    // Round robin: 0 before 6, then a new SURF 1 only after the pointer wraps.
    do_reset();
    req = 7'h41;
    cyc("rr.pick0");
    check("rr.pick0.cin", 32'(cin), 32'h01);
    complete_link(0, "rr.s0");
    cyc("rr.pick6");
    check("rr.pick6.cin", 32'(cin), 32'h40);
    req = 7'h43;
    complete_link(6, "rr.s6");
    cyc("rr.pick1");
    check("rr.pick1.cin", 32'(cin), 32'h02);
    complete_link(1, "rr.s1");
    check("rr.tc_all", 32'(tc), 32'h43);

    // CIN timeout: 2^TBITS-1 counts before FAIL, error bit after the allowed retries.
    do_reset();
    req = 7'h08;
    for (int a = 0; a < FAILS_TO_ERR; a++) begin
      cyc("to.sel");
      check($sformatf("to%0d.sel_cin", a), 32'(cin), 32'h08);
      for (int c = 0; c < LIMIT; c++) cyc("to.wait");
      check($sformatf("to%0d.still_busy", a), 32'(busy), 32'h1);
      cyc("to.fail");
      check($sformatf("to%0d.fail_noerr", a), 32'(err), 32'h0);
      cyc("to.idle");
      check($sformatf("to%0d.err", a), 32'(err), (a == FAILS_TO_ERR - 1) ? 32'h08 : 32'h0);
      check($sformatf("to%0d.cin_lo", a), 32'(cin), 32'h0);
    end

    // Abort during ALIGN.
    do_reset();
    req = 7'h10;
    cyc("ab.sel");
    rdy = 7'h10;
    cyc("ab.align");
    check("ab.areq_hi", 32'(aif.align_req_o), 32'h1);
    rdy = '0; req = '0;
    cyc("ab.abort");
    check("ab.areq_lo", 32'(aif.align_req_o), 32'h0);
    check("ab.busy_lo", 32'(busy), 32'h0);
    check("ab.err",     32'(err),  32'h0);

    // Post-live misalignment, then err_clear colliding with a new FAIL.
    do_reset();
    req = 7'h08;
    cyc("pl.sel");
    complete_link(3, "pl.s3");
    mis = 7'h08;
    cyc("pl.mis");
    mis = '0;
    check("pl.err3", 32'(err), 32'h08);
    check("pl.tc3",  32'(tc),  32'h00);
    req = 7'h28;
    cyc("pl.sel5");
    check("pl.sel5.cin", 32'(cin), 32'h20);
    rdy = 7'h20;
    cyc("pl.align5");
    rdy = '0; aif.align_err_i = 1'b1;
    cyc("pl.fail5");
    aif.align_err_i = 1'b0; eclr = 1'b1;
    cyc("pl.clear");
    eclr = 1'b0;
    check("pl.clear_vs_set", 32'(err), 32'(E_T5));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int k;
      k = $urandom_range(0, 6);
      if ($urandom_range(0, 11) == 0) req[k] = ~req[k];
      if ($urandom_range(0, 63) == 0) en = 7'($urandom) | 7'h55;
      rdy  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
      live = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
      mis  = ($urandom_range(0, 40) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'h00;
      aif.align_done_i = ($urandom_range(0, 5) == 0);
      aif.align_err_i  = ($urandom_range(0, 40) == 0);
      eclr = ($urandom_range(0, 80) == 0);
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
